// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Purpose  : Shared DES output-stage constants: widths, final permutation
//            table and the serializer state enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int c_block_w         = 64;
    localparam int c_half_w          = 32;
    localparam int c_byte_w          = 8;
    localparam int c_bytes_per_block = 8;
    localparam int c_cnt_w           = 3;

    localparam logic [c_cnt_w-1:0] c_last_cnt = 3'd7;

    // Inverse initial permutation: output DES bit i+1 comes from preoutput
    // DES bit c_fp_table[i].
    localparam int c_fp_table [0:63] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_perm.sv
`default_nettype none
// ============================================================================
// Module   : fp_perm
// Purpose  : Purely combinational DES final (inverse initial) permutation.
//            Vector index n-1 holds DES bit n on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module fp_perm
    import des_pkg::*;
(
    input  logic [c_block_w-1:0] i_x,
    output logic [c_block_w-1:0] o_ct
);

    // Each output bit is a fixed wire from one preoutput bit.
    for (genvar i = 0; i < c_block_w; i++) begin : g_bit
        localparam int c_src = c_fp_table[i] - 1;
        assign o_ct[i] = i_x[c_src];
    end

endmodule
`default_nettype wire

// File: rtl/final_perm.sv
`default_nettype none
// ============================================================================
// Module   : final_perm
// Purpose  : DES output stage. Applies the final swap and inverse initial
//            permutation to L16/R16, registers the 64-bit ciphertext and
//            streams it out one byte per accepted handshake.
// Revision : 1.0 - initial release
// ============================================================================
module final_perm
    import des_pkg::*;
#(
    parameter int REV = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [c_half_w-1:0]  L16,
    input  logic [c_half_w-1:0]  R16,
    input  logic                 IN_VLD,
    output logic                 IN_RDY,
    output logic [c_block_w-1:0] CT,
    output logic                 CT_VLD,
    output logic [c_byte_w-1:0]  OB,
    output logic                 OUT_VLD,
    input  logic                 OUT_RDY
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [c_block_w-1:0] r_ct;
    logic                 r_ct_vld;
    logic [c_block_w-1:0] w_perm;
    logic                 w_in_rdy;
    logic                 w_out_vld;
    logic                 w_capture;
    logic [c_byte_w-1:0]  w_byte;
    logic [c_byte_w-1:0]  w_ob;

    // Preoutput is R16 in DES bits 1..32 and L16 in DES bits 33..64.
    fp_perm u_fp_perm (
        .i_x  ({L16, R16}),
        .o_ct (w_perm)
    );

    assign w_capture = w_in_rdy & IN_VLD;

    // Next-state, counter and handshake decode; the last byte handshake
    // reopens the input so a waiting block is taken with no idle cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_in_rdy    = 1'b0;
        w_out_vld   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_rdy = 1'b1;
                if (IN_VLD) begin
                    w_state_nxt = ST_SEND;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SEND: begin
                w_out_vld = 1'b1;
                if (OUT_RDY) begin
                    if (r_cnt == c_last_cnt) begin
                        w_in_rdy    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IN_VLD ? ST_SEND : ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // Nothing is accepted while reset is held.
        if (RST) begin
            w_in_rdy = 1'b0;
        end
    end

    // State and byte counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Ciphertext register; held until the next capture, valid pulse follows it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ct     <= '0;
            r_ct_vld <= 1'b0;
        end else begin
            r_ct_vld <= w_capture;
            if (w_capture) begin
                r_ct <= w_perm;
            end
        end
    end

    assign w_byte = r_ct[{r_cnt, 3'b000} +: c_byte_w];

    // REV=1 presents each DES byte MSB-first (DES bit 8k+1 in OB[7]).
    if (REV != 0) begin : g_rev
        for (genvar j = 0; j < c_byte_w; j++) begin : g_bit
            assign w_ob[c_byte_w-1-j] = w_byte[j];
        end
    end else begin : g_fwd
        assign w_ob = w_byte;
    end

    assign IN_RDY  = w_in_rdy;
    assign OUT_VLD = w_out_vld;
    assign OB      = w_out_vld ? w_ob : '0;
    assign CT      = r_ct;
    assign CT_VLD  = r_ct_vld;

endmodule
`default_nettype wire

// File: tb/tb_final_perm.sv
`default_nettype none
// ============================================================================
// Module   : tb_final_perm
// Purpose  : Directed self-checking bench for final_perm (REV=1 and REV=0
//            instances driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_final_perm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] l16 = '0;
    logic [31:0] r16 = '0;
    logic        in_vld = 1'b0;
    logic        out_rdy = 1'b0;

    logic        in_rdy1, ct_vld1, out_vld1;
    logic [63:0] ct1;
    logic [7:0]  ob1;
    logic        in_rdy0, ct_vld0, out_vld0;
    logic [63:0] ct0;
    logic [7:0]  ob0;

    int errors = 0;
    int checks = 0;

    int ip_t [64] = '{58, 50, 42, 34, 26, 18, 10, 2,
                      60, 52, 44, 36, 28, 20, 12, 4,
                      62, 54, 46, 38, 30, 22, 14, 6,
                      64, 56, 48, 40, 32, 24, 16, 8,
                      57, 49, 41, 33, 25, 17,  9, 1,
                      59, 51, 43, 35, 27, 19, 11, 3,
                      61, 53, 45, 37, 29, 21, 13, 5,
                      63, 55, 47, 39, 31, 23, 15, 7};

    logic [7:0] kat_rev1 [8] = '{8'h85, 8'hE8, 8'h13, 8'h54, 8'h0F, 8'h0A, 8'hB4, 8'h05};
    logic [7:0] kat_rev0 [8] = '{8'hA1, 8'h17, 8'hC8, 8'h2A, 8'hF0, 8'h50, 8'h2D, 8'hA0};
    logic [7:0] p2_rev1  [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    logic [63:0] kat_ct_vec;
    logic [63:0] p2_vec;

    final_perm #(.REV(1)) u_dut1 (
        .CLK(clk), .RST(rst), .L16(l16), .R16(r16), .IN_VLD(in_vld), .IN_RDY(in_rdy1),
        .CT(ct1), .CT_VLD(ct_vld1), .OB(ob1), .OUT_VLD(out_vld1), .OUT_RDY(out_rdy)
    );

    final_perm #(.REV(0)) u_dut0 (
        .CLK(clk), .RST(rst), .L16(l16), .R16(r16), .IN_VLD(in_vld), .IN_RDY(in_rdy0),
        .CT(ct0), .CT_VLD(ct_vld0), .OB(ob0), .OUT_VLD(out_vld0), .OUT_RDY(out_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    function automatic logic [63:0] ip_perm(input logic [63:0] p);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = p[ip_t[i]-1];
        return r;
    endfunction

    task automatic set_kat();
        l16 = rev32(32'h43423234);
        r16 = rev32(32'h0A4CD995);
    endtask

    task automatic set_block(input logic [63:0] p);
        logic [63:0] x;
        x   = ip_perm(p);
        l16 = x[63:32];
        r16 = x[31:0];
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (in_rdy1 !== 1'b0)  begin errors++; $display("FAIL reset_in_rdy: got %b want 0", in_rdy1); end
        checks++; if (out_vld1 !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b want 0", out_vld1); end
        checks++; if (ob1 !== 8'h00)     begin errors++; $display("FAIL reset_ob: got %h want 00", ob1); end
        checks++; if (ct1 !== 64'h0)     begin errors++; $display("FAIL reset_ct: got %h want 0", ct1); end
        checks++; if (ct_vld1 !== 1'b0)  begin errors++; $display("FAIL reset_ct_vld: got %b want 0", ct_vld1); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (in_rdy1 !== 1'b1)  begin errors++; $display("FAIL idle_in_rdy: got %b want 1", in_rdy1); end
        checks++; if (out_vld1 !== 1'b0) begin errors++; $display("FAIL idle_out_vld: got %b want 0", out_vld1); end
    endtask

    task automatic test_kat();
        logic exp_rdy;
        @(negedge clk); set_kat(); in_vld = 1'b1; out_rdy = 1'b1; #1;
        checks++; if (in_rdy1 !== 1'b1) begin errors++; $display("FAIL kat_idle_rdy: got %b want 1", in_rdy1); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); in_vld = 1'b0; #1;
            exp_rdy = (k == 7);
            if (k == 0) begin
                checks++; if (ct_vld1 !== 1'b1)    begin errors++; $display("FAIL kat_ct_vld: got %b want 1", ct_vld1); end
                checks++; if (ct1 !== kat_ct_vec)  begin errors++; $display("FAIL kat_ct_rev1: got %h want %h", ct1, kat_ct_vec); end
                checks++; if (ct0 !== kat_ct_vec)  begin errors++; $display("FAIL kat_ct_rev0: got %h want %h", ct0, kat_ct_vec); end
            end else begin
                checks++; if (ct_vld1 !== 1'b0)    begin errors++; $display("FAIL kat_ct_vld_pulse k=%0d: got %b want 0", k, ct_vld1); end
            end
            checks++; if (out_vld1 !== 1'b1)       begin errors++; $display("FAIL kat_out_vld k=%0d: got %b want 1", k, out_vld1); end
            checks++; if (ob1 !== kat_rev1[k])     begin errors++; $display("FAIL kat_ob_rev1 k=%0d: got %h want %h", k, ob1, kat_rev1[k]); end
            checks++; if (ob0 !== kat_rev0[k])     begin errors++; $display("FAIL kat_ob_rev0 k=%0d: got %h want %h", k, ob0, kat_rev0[k]); end
            checks++; if (in_rdy1 !== exp_rdy)     begin errors++; $display("FAIL kat_in_rdy k=%0d: got %b want %b", k, in_rdy1, exp_rdy); end
        end
        @(negedge clk); #1;
        checks++; if (out_vld1 !== 1'b0)      begin errors++; $display("FAIL kat_done_vld: got %b want 0", out_vld1); end
        checks++; if (in_rdy1 !== 1'b1)       begin errors++; $display("FAIL kat_done_rdy: got %b want 1", in_rdy1); end
        checks++; if (ct1 !== kat_ct_vec)     begin errors++; $display("FAIL kat_ct_hold: got %h want %h", ct1, kat_ct_vec); end
    endtask

    task automatic test_random_ip();
        logic [63:0] p;
        int t;
        out_rdy = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            p = {$urandom(), $urandom()};
            @(negedge clk); set_block(p); in_vld = 1'b1; #1;
            t = 0;
            while (in_rdy1 !== 1'b1 && t < 20) begin
                @(negedge clk); #1; t++;
            end
            if (t >= 20) begin
                checks++; errors++;
                $display("FAIL rand_wait_rdy v=%0d: got in_rdy=%b want 1 within 20 cycles", v, in_rdy1);
            end else begin
                @(negedge clk); in_vld = 1'b0; #1;
                checks++; if (ct1 !== p) begin errors++; $display("FAIL rand_ct v=%0d: got %h want %h", v, ct1, p); end
            end
        end
        in_vld = 1'b0;
        t = 0;
        while (out_vld1 !== 1'b0 && t < 20) begin
            @(negedge clk); #1; t++;
        end
        checks++; if (out_vld1 !== 1'b0) begin errors++; $display("FAIL rand_drain: got out_vld=%b want 0", out_vld1); end
    endtask

    task automatic test_stall();
        int idx, t;
        logic exp_rdy;
        @(negedge clk); set_kat(); in_vld = 1'b1; out_rdy = 1'b0;
        idx = 0; t = 0;
        while (idx < 8 && t < 200) begin
            @(negedge clk); in_vld = 1'b0; out_rdy = 1'($urandom_range(0, 1)); #1; t++;
            exp_rdy = (idx == 7) && out_rdy;
            checks++; if (out_vld1 !== 1'b1)   begin errors++; $display("FAIL stall_vld idx=%0d: got %b want 1", idx, out_vld1); end
            checks++; if (ob1 !== kat_rev1[idx]) begin errors++; $display("FAIL stall_ob idx=%0d: got %h want %h", idx, ob1, kat_rev1[idx]); end
            checks++; if (in_rdy1 !== exp_rdy) begin errors++; $display("FAIL stall_in_rdy idx=%0d: got %b want %b", idx, in_rdy1, exp_rdy); end
            if (out_rdy) idx++;
        end
        checks++; if (idx != 8) begin errors++; $display("FAIL stall_count: got %0d bytes want 8", idx); end
        out_rdy = 1'b1;
        @(negedge clk); #1;
        checks++; if (out_vld1 !== 1'b0) begin errors++; $display("FAIL stall_extra_byte: got out_vld=%b want 0", out_vld1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_ob;
        logic exp_rdy;
        @(negedge clk); set_kat(); in_vld = 1'b1; out_rdy = 1'b1; #1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) set_block(p2_vec);
            if (c == 15) in_vld = 1'b0;
            #1;
            exp_ob  = (c < 8) ? kat_rev1[c] : p2_rev1[c-8];
            exp_rdy = ((c % 8) == 7);
            checks++; if (out_vld1 !== 1'b1) begin errors++; $display("FAIL b2b_vld c=%0d: got %b want 1", c, out_vld1); end
            checks++; if (ob1 !== exp_ob)    begin errors++; $display("FAIL b2b_ob c=%0d: got %h want %h", c, ob1, exp_ob); end
            checks++; if (in_rdy1 !== exp_rdy) begin errors++; $display("FAIL b2b_in_rdy c=%0d: got %b want %b", c, in_rdy1, exp_rdy); end
            if (c == 8) begin
                checks++; if (ct_vld1 !== 1'b1) begin errors++; $display("FAIL b2b_ct_vld: got %b want 1", ct_vld1); end
                checks++; if (ct1 !== p2_vec)   begin errors++; $display("FAIL b2b_ct: got %h want %h", ct1, p2_vec); end
            end
        end
        @(negedge clk); #1;
        checks++; if (out_vld1 !== 1'b0) begin errors++; $display("FAIL b2b_end_vld: got %b want 0", out_vld1); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); set_kat(); in_vld = 1'b1; out_rdy = 1'b1;
        @(negedge clk); in_vld = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ob1 !== kat_rev1[3]) begin errors++; $display("FAIL mid_byte3: got %h want %h", ob1, kat_rev1[3]); end
        #1; rst = 1'b1; #1;
        checks++; if (out_vld1 !== 1'b0) begin errors++; $display("FAIL mid_async_vld: got %b want 0", out_vld1); end
        checks++; if (ob1 !== 8'h00)     begin errors++; $display("FAIL mid_async_ob: got %h want 00", ob1); end
        checks++; if (in_rdy1 !== 1'b0)  begin errors++; $display("FAIL mid_async_rdy: got %b want 0", in_rdy1); end
        checks++; if (ct1 !== 64'h0)     begin errors++; $display("FAIL mid_async_ct: got %h want 0", ct1); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++; if (out_vld1 !== 1'b0) begin errors++; $display("FAIL mid_no_partial i=%0d: got %b want 0", i, out_vld1); end
        end
        @(negedge clk); set_block(p2_vec); in_vld = 1'b1;
        @(negedge clk); in_vld = 1'b0; #1;
        checks++; if (ob1 !== 8'h01) begin errors++; $display("FAIL mid_new_byte0_rev1: got %h want 01", ob1); end
        checks++; if (ob0 !== 8'h80) begin errors++; $display("FAIL mid_new_byte0_rev0: got %h want 80", ob0); end
        @(negedge clk); #1;
        checks++; if (ob1 !== 8'h23) begin errors++; $display("FAIL mid_new_byte1_rev1: got %h want 23", ob1); end
        checks++; if (ob0 !== 8'hC4) begin errors++; $display("FAIL mid_new_byte1_rev0: got %h want C4", ob0); end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        kat_ct_vec = rev64(64'h85E813540F0AB405);
        p2_vec     = rev64(64'h0123456789ABCDEF);
        test_reset();
        test_kat();
        test_random_ip();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
